shift_rotate_sequencer: RTL and testbench

//  Multi-cycle controller for the ALU's 16-bit shift/rotate path. Accepts one op
//  (ROL/ROR/SHL/SHR/ASR, amount 0..15) over a valid/ready handshake, iterates a
//  1-bit step per cycle on an internal working register, then presents the result
//  and Z/N/C/V flags until consumed. Sits between the issue stage and writeback,

---
 rtl/shift_rotate_sequencer.sv | 155 +++++++++++++++
 tb/tb_shift_rotate_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rotate_sequencer.sv
// Multi-cycle 16-bit shift/rotate sequencer: one op per valid/ready handshake, result and flags held until consumed.
// Optional macro SHIFT_BY_FOUR_EN adds a 4-bit step while the remaining count is at least four.
module shift_rotate_sequencer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_z,
  output logic             out_n,
  output logic             out_c,
  output logic             out_v,
  output logic             busy
);

  localparam logic [2:0] OP_ROL = 3'd0;
  localparam logic [2:0] OP_ROR = 3'd1;
  localparam logic [2:0] OP_SHL = 3'd2;
  localparam logic [2:0] OP_SHR = 3'd3;
  localparam logic [2:0] OP_ASR = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       op;
  logic [AMT_W-1:0] count;
  logic [WIDTH-1:0] work;
  logic             carry;

  logic [WIDTH-1:0] step_data;
  logic             step_carry;
  logic [AMT_W-1:0] step_dec;
  logic             accept;

  // Single-bit step; rotates pass the carry through untouched (it stays 0 from accept).
  function automatic logic [WIDTH:0] step1(input logic [2:0] o, input logic [WIDTH-1:0] x,
                                           input logic ci);
    step1 = {ci, x};
    case (o)
      OP_ROL:  step1 = {ci, x[WIDTH-2:0], x[WIDTH-1]};
      OP_ROR:  step1 = {ci, x[0], x[WIDTH-1:1]};
      OP_SHL:  step1 = {x[WIDTH-1], x[WIDTH-2:0], 1'b0};
      OP_SHR:  step1 = {x[0], 1'b0, x[WIDTH-1:1]};
      OP_ASR:  step1 = {x[0], x[WIDTH-1], x[WIDTH-1:1]};
      default: step1 = {ci, x};
    endcase
  endfunction

`ifdef SHIFT_BY_FOUR_EN
  // Four-bit step equal to four single steps; carry is the last bit shifted out.
  function automatic logic [WIDTH:0] step4(input logic [2:0] o, input logic [WIDTH-1:0] x,
                                           input logic ci);
    step4 = {ci, x};
    case (o)
      OP_ROL:  step4 = {ci, x[WIDTH-5:0], x[WIDTH-1:WIDTH-4]};
      OP_ROR:  step4 = {ci, x[3:0], x[WIDTH-1:4]};
      OP_SHL:  step4 = {x[WIDTH-4], x[WIDTH-5:0], 4'b0000};
      OP_SHR:  step4 = {x[3], 4'b0000, x[WIDTH-1:4]};
      OP_ASR:  step4 = {x[3], {4{x[WIDTH-1]}}, x[WIDTH-1:4]};
      default: step4 = {ci, x};
    endcase
  endfunction
`endif

  assign accept = (state == IDLE) && in_valid;

  // Next working value and how far the remaining count drops this cycle.
  always_comb begin
    step_dec = AMT_W'(1);
`ifdef SHIFT_BY_FOUR_EN
    if (count >= AMT_W'(4)) begin
      {step_carry, step_data} = step4(op, work, carry);
      step_dec = AMT_W'(4);
    end else begin
      {step_carry, step_data} = step1(op, work, carry);
    end
`else
    {step_carry, step_data} = step1(op, work, carry);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op    <= OP_ROL;
      count <= '0;
      work  <= '0;
      carry <= 1'b0;
    end else if (accept) begin
      op    <= (in_op > OP_ASR) ? OP_ROL : in_op;
      count <= in_amt;
      work  <= in_data;
      carry <= 1'b0;
    end else if (state == RUN) begin
      count <= count - step_dec;
      work  <= step_data;
      carry <= step_carry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = (in_amt == '0) ? DONE : RUN;
      RUN:  if (count == step_dec) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and flags decode straight from registered state and working value.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_data  = work;
    out_z     = 1'b0;
    out_n     = 1'b0;
    out_c     = 1'b0;
    out_v     = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      RUN:  busy = 1'b1;
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_z     = (work == '0);
        out_n     = work[WIDTH-1];
        out_c     = carry;
      end
      default: in_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_shift_rotate_sequencer.sv
// Bench for shift_rotate_sequencer: arithmetic reference model checked every cycle plus directed literal vectors.
module tb_shift_rotate_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [15:0] in_data;
  logic [3:0]  in_amt;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_z, out_n, out_c, out_v;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  shift_rotate_sequencer #(.WIDTH(16), .AMT_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_data(in_data), .in_amt(in_amt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_z(out_z), .out_n(out_n), .out_c(out_c), .out_v(out_v), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycles spent in RUN for a given amount.
  function automatic int steps_of(input int a);
`ifdef SHIFT_BY_FOUR_EN
    return a / 4 + a % 4;
`else
    return a;
`endif
  endfunction

  // Reference result {carry, data} computed directly from the operation definitions.
  function automatic logic [16:0] model_res(input logic [2:0] op, input logic [15:0] d, input int a);
    int unsigned x;
    int          sx;
    int unsigned r;
    logic        c;
    x  = d;
    sx = $signed(d);
    c  = 1'b0;
    case ((op > 3'd4) ? 3'd0 : op)
      3'd0: r = ((x << a) | (x >> (16 - a))) & 32'hFFFF;
      3'd1: r = ((x >> a) | (x << (16 - a))) & 32'hFFFF;
      3'd2: begin r = (x << a) & 32'hFFFF; if (a > 0) c = x[16 - a]; end
      3'd3: begin r = x >> a; if (a > 0) c = x[a - 1]; end
      default: begin r = (sx >>> a) & 32'hFFFF; if (a > 0) c = x[a - 1]; end
    endcase
    return {c, r[15:0]};
  endfunction

  // Expected transaction phase: 0 idle, 1 computing, 2 result presented.
  int          m_phase = 0;
  int          m_left  = 0;
  bit          m_live  = 1'b0;
  logic [15:0] m_res   = '0;
  logic        m_c     = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_live  = 1'b1;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          {m_c, m_res} = model_res(in_op, in_data, int'(in_amt));
          m_left  = steps_of(int'(in_amt));
          m_phase = (m_left == 0) ? 2 : 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("cyc_in_ready", in_ready, m_phase == 0);
      check("cyc_out_valid", out_valid, m_phase == 2);
      check("cyc_busy", busy, m_phase != 0);
      if (m_phase == 2) begin
        check("cyc_data", out_data, m_res);
        check("cyc_z", out_z, m_res == 16'h0);
        check("cyc_n", out_n, m_res[15]);
        check("cyc_c", out_c, m_c);
        check("cyc_v", out_v, 1'b0);
      end
    end
  end

  // Issue one op from a negedge, wait for the result, check literals, then hold for extra cycles.
  task automatic run_op(input string name, input logic [2:0] op, input logic [15:0] d,
                        input logic [3:0] a, input logic [15:0] exp_d, input logic exp_z,
                        input logic exp_n, input logic exp_c, input int exp_lat, input int hold);
    int lat;
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_amt   = a;
    check({name, "_ready_at_issue"}, in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_op    = 3'($urandom);
    in_data  = 16'($urandom);
    in_amt   = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_data"}, out_data, exp_d);
    check({name, "_z"}, out_z, exp_z);
    check({name, "_n"}, out_n, exp_n);
    check({name, "_c"}, out_c, exp_c);
    check({name, "_ready_in_done"}, in_ready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, "_hold_data"}, out_data, exp_d);
      check({name, "_hold_ready"}, in_ready, 1'b0);
    end
  endtask

  task automatic release_result(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_idle_ready"}, in_ready, 1'b1);
    check({name, "_idle_valid"}, out_valid, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = '0;
    in_data   = '0;
    in_amt    = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_data", out_data, 16'h0);
    check("rst_flags", {out_z, out_n, out_c, out_v}, 4'b0000);
    rst = 1'b0;
    @(negedge clk);

    run_op("rol1", 3'd0, 16'h8001, 4'd1, 16'h0003, 1'b0, 1'b0, 1'b0, 2, 0);
    release_result("rol1");
`ifdef SHIFT_BY_FOUR_EN
    run_op("ror4", 3'd1, 16'h0001, 4'd4, 16'h1000, 1'b0, 1'b0, 1'b0, 2, 0);
`else
    run_op("ror4", 3'd1, 16'h0001, 4'd4, 16'h1000, 1'b0, 1'b0, 1'b0, 5, 0);
`endif
    release_result("ror4");
    run_op("shl1", 3'd2, 16'h8000, 4'd1, 16'h0000, 1'b1, 1'b0, 1'b1, steps_of(1) + 1, 0);
    release_result("shl1");
    run_op("asr15", 3'd4, 16'h8000, 4'd15, 16'hFFFF, 1'b0, 1'b1, 1'b0, steps_of(15) + 1, 0);
    release_result("asr15");
    run_op("shr0", 3'd3, 16'h1234, 4'd0, 16'h1234, 1'b0, 1'b0, 1'b0, 1, 0);
    release_result("shr0");
    run_op("ror5", 3'd1, 16'h1234, 4'd5, 16'hA091, 1'b0, 1'b1, 1'b0, steps_of(5) + 1, 0);
    release_result("ror5");
    run_op("shr15", 3'd3, 16'h8001, 4'd15, 16'h0001, 1'b0, 1'b0, 1'b0, steps_of(15) + 1, 0);
    release_result("shr15");
    run_op("shl9", 3'd2, 16'h00F0, 4'd9, 16'hE000, 1'b0, 1'b1, 1'b1, steps_of(9) + 1, 0);
    release_result("shl9");
    run_op("asr14", 3'd4, 16'h4000, 4'd14, 16'h0001, 1'b0, 1'b0, 1'b0, steps_of(14) + 1, 0);
    release_result("asr14");
    run_op("op6rol", 3'd6, 16'h1234, 4'd4, 16'h2341, 1'b0, 1'b0, 1'b0, steps_of(4) + 1, 0);
    release_result("op6rol");

    // Backpressure, then a request arriving in the same cycle as the hand-off must stall.
    run_op("bp", 3'd3, 16'hF00F, 4'd2, 16'h3C03, 1'b0, 1'b0, 1'b1, steps_of(2) + 1, 10);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = 3'd2;
    in_data   = 16'h0001;
    in_amt    = 4'd3;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_stall_busy", busy, 1'b0);
    check("bp_stall_ready", in_ready, 1'b1);
    run_op("bp_next", 3'd2, 16'h0001, 4'd3, 16'h0008, 1'b0, 1'b0, 1'b0, steps_of(3) + 1, 0);
    release_result("bp_next");

    // Reset while computing abandons the op.
    in_valid = 1'b1;
    in_op    = 3'd0;
    in_data  = 16'hABCD;
    in_amt   = 4'd15;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ready", in_ready, 1'b1);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_data", out_data, 16'h0);
    run_op("after_rst", 3'd0, 16'h8001, 4'd1, 16'h0003, 1'b0, 1'b0, 1'b0, 2, 0);
    release_result("after_rst");

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
